// File: rtl/rv_pipe_pkg.sv
// Shared pipeline types: fetch FSM states, the bubble instruction and the IF/ID register layout.
package rv_pipe_pkg;

  // ifid_t is sized by this width, so fetch_stage's PC_W must match it.
  localparam int unsigned IFID_PC_W = 9;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_DROP
  } fetch_state_e;

  typedef struct packed {
    logic                 valid;
    logic [IFID_PC_W-1:0] pc;
    logic [31:0]          instr;
  } ifid_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry buffer that parks a fetched word while the hazard unit stalls IF/ID.
module fetch_hold_buf
  import rv_pipe_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 clear,
  input  logic [IFID_PC_W-1:0] load_pc,
  input  logic [31:0]          load_instr,
  output ifid_t                word
);

  logic                 valid_q;
  logic [IFID_PC_W-1:0] pc_q;
  logic [31:0]          instr_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) valid_q <= 1'b0;
    else if (load)      valid_q <= 1'b1;
  end

  // NOTE: the payload is not reset; valid_q alone qualifies it, so the data flops stay reset-free.
  always_ff @(posedge clk) begin
    if (load) begin
      pc_q    <= load_pc;
      instr_q <= load_instr;
    end
  end

  assign word = '{valid: valid_q, pc: pc_q, instr: instr_q};

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, req/ack instruction fetch FSM, IF/ID register and redirect counter.
module fetch_stage
  import rv_pipe_pkg::*;
#(
  parameter int unsigned PC_W      = IFID_PC_W,
  parameter logic [31:0] NOP_INSTR = rv_pipe_pkg::NOP_INSTR,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             pc_sel,
  input  logic [31:0]      branch_target,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             ifid_valid,
  output logic [PC_W-1:0]  ifid_pc,
  output logic [31:0]      ifid_instr,
  output logic [CNT_W-1:0] redirect_cnt
);

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  target_q, target_d;
  ifid_t            ifid_q, ifid_d;
  logic [CNT_W-1:0] cnt_q;

  logic             hold_load, hold_clear;
  ifid_t            hold_word;
  ifid_t            word;
  logic             word_ok;

  logic [PC_W-1:0]  redirect_pc;
  logic [PC_W-1:0]  pc_inc;
  logic             unused_target_bits;

  assign redirect_pc        = {branch_target[PC_W-1:2], 2'b00};
  assign pc_inc             = pc_q + PC_W'(4);
  assign unused_target_bits = ^{branch_target[31:PC_W], branch_target[1:0]};

  fetch_hold_buf u_hold_buf (
    .clk        (clk),
    .reset      (reset),
    .load       (hold_load),
    .clear      (hold_clear),
    .load_pc    (pc_q),
    .load_instr (imem_rdata),
    .word       (hold_word)
  );

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    target_d   = target_q;
    imem_req   = 1'b0;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    word_ok    = 1'b0;
    word       = '{valid: 1'b1, pc: pc_q, instr: imem_rdata};

    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (pc_sel) pc_d = redirect_pc;
      end
      S_REQ: begin
        imem_req = 1'b1;
        if (imem_ack && pc_sel) begin
          pc_d = redirect_pc;
        end else if (imem_ack) begin
          pc_d = pc_inc;
          if (stall) begin
            hold_load = 1'b1;
            state_d   = S_HOLD;
          end else begin
            word_ok = 1'b1;
          end
        end else if (pc_sel) begin
          // The bus cannot withdraw a request: remember where to go once it completes.
          target_d = redirect_pc;
          state_d  = S_DROP;
        end
      end
      S_HOLD: begin
        if (pc_sel) begin
          hold_clear = 1'b1;
          pc_d       = redirect_pc;
          state_d    = S_REQ;
        end else if (!stall) begin
          hold_clear = 1'b1;
          word       = hold_word;
          word_ok    = 1'b1;
          state_d    = S_REQ;
        end
      end
      S_DROP: begin
        imem_req = 1'b1;
        if (pc_sel) target_d = redirect_pc;
        if (imem_ack) begin
          pc_d    = target_d;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Redirect flushes even under stall; otherwise stall holds, then new word, else bubble.
    if (pc_sel)       ifid_d = '{valid: 1'b0, pc: ifid_q.pc, instr: NOP_INSTR};
    else if (stall)   ifid_d = ifid_q;
    else if (word_ok) ifid_d = word;
    else              ifid_d = '{valid: 1'b0, pc: ifid_q.pc, instr: NOP_INSTR};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      target_q <= '0;
      ifid_q   <= '{valid: 1'b0, pc: '0, instr: NOP_INSTR};
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      ifid_q   <= ifid_d;
      if (pc_sel && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign imem_addr    = pc_q;
  assign ifid_valid   = ifid_q.valid;
  assign ifid_pc      = ifid_q.pc;
  assign ifid_instr   = ifid_q.instr;
  assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: variable-latency imem model plus an IF/ID scoreboard.
module tb_fetch_stage;

  localparam int PC_W  = 9;
  localparam int CNT_W = 16;
  localparam int DEPTH = 1 << (PC_W - 2);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             stall = 1'b0;
  logic             pc_sel = 1'b0;
  logic [31:0]      branch_target = '0;
  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic             imem_ack;
  logic [31:0]      imem_rdata;
  logic             ifid_valid;
  logic [PC_W-1:0]  ifid_pc;
  logic [31:0]      ifid_instr;
  logic [CNT_W-1:0] redirect_cnt;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [DEPTH];
  int  lat_cfg = 0;
  bit  lat_rand = 1'b0;
  int  cur_lat = 0;
  int  wait_cnt = 0;

  typedef struct {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;
  bit   mon_en = 1'b0;

  logic            stall_q = 1'b0, pcsel_q = 1'b0, rst_q = 1'b1;
  logic            pend = 1'b0;
  logic [PC_W-1:0] pend_addr = '0;

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .pc_sel        (pc_sel),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .ifid_valid    (ifid_valid),
    .ifid_pc       (ifid_pc),
    .ifid_instr    (ifid_instr),
    .redirect_cnt  (redirect_cnt)
  );

  initial forever #5 clk = ~clk;

  // Instruction memory: ack after a per-request wait, same cycle as req when the wait is zero.
  assign imem_ack   = imem_req && (wait_cnt >= (lat_rand ? cur_lat : lat_cfg));
  assign imem_rdata = mem[imem_addr[PC_W-1:2]];

  always @(posedge clk) begin
    if (reset || imem_ack || !imem_req) wait_cnt <= 0;
    else                                wait_cnt <= wait_cnt + 1;
    if (reset || imem_ack) cur_lat <= $urandom_range(0, 3);
    stall_q   <= stall;
    pcsel_q   <= pc_sel;
    rst_q     <= reset;
    pend      <= !reset && imem_req && !imem_ack;
    pend_addr <= imem_addr;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [PC_W-1:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = mem[pc[PC_W-1:2]];
    sb_q.push_back(e);
  endtask

  // Pops the scoreboard on every freshly loaded IF/ID word and checks the request protocol.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst_q && pend) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== pend_addr) begin
          failures++;
          $display("FAIL req_held: req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, pend_addr);
        end
      end
      if (mon_en && !rst_q && !(stall_q && !pcsel_q) && ifid_valid === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL sb_extra: got pc=%h instr=%h, required no new word", ifid_pc, ifid_instr);
        end else begin
          mon_e = sb_q.pop_front();
          if (ifid_pc !== mon_e.pc || ifid_instr !== mon_e.instr) begin
            failures++;
            $display("FAIL sb_word: got pc=%h instr=%h, required pc=%h instr=%h",
                     ifid_pc, ifid_instr, mon_e.pc, mon_e.instr);
          end
        end
      end
    end
  endtask

  task automatic do_reset(input int lat);
    mon_en = 1'b0; reset = 1'b1; stall = 1'b0; pc_sel = 1'b0;
    branch_target = '0; lat_cfg = lat; lat_rand = 1'b0;
    repeat (2) step();
    sb_q.delete();
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    mon_en = 1'b0; reset = 1'b1; stall = 1'b0; pc_sel = 1'b0; lat_cfg = 0; lat_rand = 1'b0;
    repeat (2) step();
    checks++;
    if (imem_req !== 1'b0 || ifid_valid !== 1'b0 || ifid_pc !== '0 || ifid_instr !== 32'h0000_0013 ||
        redirect_cnt !== '0 || imem_addr !== '0) begin
      failures++;
      $display("FAIL reset_vals: req=%b valid=%b pc=%h instr=%h cnt=%h addr=%h, required 0 0 0 00000013 0 0",
               imem_req, ifid_valid, ifid_pc, ifid_instr, redirect_cnt, imem_addr);
    end
    reset = 1'b0;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== '0) begin
      failures++;
      $display("FAIL reset_first_req: req=%b addr=%h, required req=1 addr=000", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    do_reset(0);
    for (int k = 0; k < 10; k++) push(PC_W'(4 * k));
    for (int k = 1; k <= 11; k++) begin
      step();
      checks++;
      if (ifid_valid !== logic'(k >= 2)) begin
        failures++;
        $display("FAIL seq_valid k=%0d: valid=%b, required %b", k, ifid_valid, k >= 2);
      end
      if (k >= 2) begin
        checks++;
        if (ifid_pc !== PC_W'(4 * (k - 2))) begin
          failures++;
          $display("FAIL seq_pc k=%0d: pc=%h, required %h", k, ifid_pc, PC_W'(4 * (k - 2)));
        end
      end
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL seq_drain: %0d words missing, required 0", sb_q.size());
    end
    mon_en = 1'b0;
  endtask

  task automatic test_stall();
    logic [PC_W-1:0] exp_pc [9] = '{0, 0, 0, 4, 4, 4, 4, 8, 12};
    do_reset(0);
    push(0); push(4); push(8); push(12);
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k >= 2) begin
        checks++;
        if (ifid_valid !== 1'b1 || ifid_pc !== exp_pc[k]) begin
          failures++;
          $display("FAIL stall_ifid k=%0d: valid=%b pc=%h, required valid=1 pc=%h", k, ifid_valid, ifid_pc, exp_pc[k]);
        end
      end
      if (k >= 4 && k <= 6) begin
        checks++;
        if (imem_req !== 1'b0) begin
          failures++;
          $display("FAIL stall_hold_req k=%0d: req=%b, required 0", k, imem_req);
        end
      end
      stall = (k >= 3 && k < 6);
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL stall_drain: %0d words missing, required 0", sb_q.size());
    end
    mon_en = 1'b0;
  endtask

  task automatic test_redirect();
    do_reset(4);
    branch_target = 32'h43;
    push(PC_W'(9'h040));
    for (int k = 1; k <= 11; k++) begin
      step();
      checks++;
      if (ifid_valid !== logic'(k == 11)) begin
        failures++;
        $display("FAIL redir_valid k=%0d: valid=%b, required %b", k, ifid_valid, k == 11);
      end
      if (k >= 3 && k <= 5) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== '0) begin
          failures++;
          $display("FAIL redir_drop k=%0d: req=%b addr=%h, required req=1 addr=000", k, imem_req, imem_addr);
        end
      end
      if (k >= 6 && k <= 10) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 9'h040) begin
          failures++;
          $display("FAIL redir_addr k=%0d: req=%b addr=%h, required req=1 addr=040", k, imem_req, imem_addr);
        end
      end
      if (k == 11) begin
        checks++;
        if (ifid_pc !== 9'h040 || redirect_cnt !== 16'd1) begin
          failures++;
          $display("FAIL redir_land: pc=%h cnt=%h, required pc=040 cnt=0001", ifid_pc, redirect_cnt);
        end
      end
      pc_sel = (k == 2);
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL redir_drain: %0d words missing, required 0", sb_q.size());
    end
    mon_en = 1'b0;
  endtask

  task automatic test_flush_stall();
    do_reset(0);
    branch_target = 32'h100;
    push(0); push(4); push(PC_W'(9'h100)); push(PC_W'(9'h104));
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 4) begin
        checks++;
        if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0000_0013 || imem_req !== 1'b1 ||
            imem_addr !== 9'h100 || redirect_cnt !== 16'd1) begin
          failures++;
          $display("FAIL flush_stall: valid=%b instr=%h req=%b addr=%h cnt=%h, required 0 00000013 1 100 0001",
                   ifid_valid, ifid_instr, imem_req, imem_addr, redirect_cnt);
        end
      end
      if (k == 5) begin
        checks++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 9'h100) begin
          failures++;
          $display("FAIL flush_target: valid=%b pc=%h, required valid=1 pc=100", ifid_valid, ifid_pc);
        end
      end
      stall  = (k == 3);
      pc_sel = (k == 3);
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL flush_drain: %0d words missing, required 0", sb_q.size());
    end
    mon_en = 1'b0;
  endtask

  task automatic test_wrap();
    logic [PC_W-1:0] exp_pc [4] = '{9'h1F8, 9'h1FC, 9'h000, 9'h004};
    do_reset(0);
    branch_target = 32'h1F8;
    push(0); push(PC_W'(9'h1F8)); push(PC_W'(9'h1FC)); push(0); push(4);
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k >= 4) begin
        checks++;
        if (ifid_valid !== 1'b1 || ifid_pc !== exp_pc[k-4] || $isunknown(ifid_instr)) begin
          failures++;
          $display("FAIL wrap k=%0d: valid=%b pc=%h instr=%h, required valid=1 pc=%h", k, ifid_valid, ifid_pc, ifid_instr, exp_pc[k-4]);
        end
      end
      pc_sel = (k == 2);
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL wrap_drain: %0d words missing, required 0", sb_q.size());
    end
    mon_en = 1'b0;
  endtask

  task automatic test_random_latency();
    do_reset(0);
    lat_rand = 1'b1;
    for (int k = 0; k < 20; k++) push(PC_W'(4 * k));
    for (int k = 0; k < 200 && sb_q.size() != 0; k++) step();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL randlat_drain: %0d words missing, required 0", sb_q.size());
    end
    mon_en = 1'b0;
    lat_rand = 1'b0;
  endtask

  task automatic test_reset_drop();
    do_reset(4);
    branch_target = 32'h80;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 5) begin
        checks++;
        if (imem_req !== 1'b0 || ifid_valid !== 1'b0 || ifid_pc !== '0 || ifid_instr !== 32'h0000_0013 ||
            redirect_cnt !== '0 || imem_addr !== '0) begin
          failures++;
          $display("FAIL drop_reset: req=%b valid=%b pc=%h instr=%h cnt=%h addr=%h, required 0 0 0 00000013 0 0",
                   imem_req, ifid_valid, ifid_pc, ifid_instr, redirect_cnt, imem_addr);
        end
      end
      if (k == 6) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== '0) begin
          failures++;
          $display("FAIL drop_restart: req=%b addr=%h, required req=1 addr=000", imem_req, imem_addr);
        end
      end
      if (k == 7) begin
        checks++;
        if (ifid_valid !== 1'b1 || ifid_pc !== '0) begin
          failures++;
          $display("FAIL drop_first: valid=%b pc=%h, required valid=1 pc=000", ifid_valid, ifid_pc);
        end
      end
      pc_sel = (k == 2);
      if (k == 4) reset = 1'b1;
      if (k == 5) begin
        reset   = 1'b0;
        lat_cfg = 0;
        push(0);
      end
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drop_drain: %0d words missing, required 0", sb_q.size());
    end
    mon_en = 1'b0;
  endtask

  task automatic test_saturate();
    logic [CNT_W-1:0] exp_cnt;
    do_reset(0);
    mon_en = 1'b0;
    branch_target = 32'h20;
    pc_sel = 1'b1;
    for (int k = 1; k <= 65540; k++) begin
      step();
      if (k == 1 || k == 65534 || k == 65535 || k == 65540) begin
        exp_cnt = (k >= 65535) ? 16'hFFFF : CNT_W'(k);
        checks++;
        if (redirect_cnt !== exp_cnt) begin
          failures++;
          $display("FAIL cnt_sat k=%0d: cnt=%h, required %h", k, redirect_cnt, exp_cnt);
        end
      end
    end
    pc_sel = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    fork
      monitor();
    join_none
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_flush_stall();
    test_wrap();
    test_random_latency();
    test_reset_drop();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
